// File: rtl/arbitro_memoria_pkg.sv
// Shared constants for the two-port memory arbiter: default widths,
// FSM state encoding and port index values.
package arbitro_memoria_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter giving two request ports pipelined access to a single
// external data memory: grant cycle, memory access cycle, then ack pulse.
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_position,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_mw,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t state;
  state_t state_nxt;
  logic   prio;    // port that wins when both request
  logic   port_q;  // owner of the access in flight
  logic   we_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration, next state and memory write strobe; all forced low in reset
  always_comb begin
    state_nxt = IDLE;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_mw    = 1'b0;
    if (rst_n) begin
      if (req0 && (!req1 || prio == PORT0)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
      case (state)
        IDLE:    mem_mw = 1'b0;
        ACC:     mem_mw = we_q;
        default: mem_mw = 1'b0;
      endcase
      if (gnt0 || gnt1) begin
        state_nxt = ACC;
      end
    end
  end

  // Access capture at grant, read capture and ack at the end of ACC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio         <= PORT0;
      port_q       <= PORT0;
      we_q         <= 1'b0;
      mem_position <= '0;
      mem_data_in  <= '0;
      rdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
    end else begin
      ack0 <= (state == ACC) && (port_q == PORT0);
      ack1 <= (state == ACC) && (port_q == PORT1);
      if (state == ACC && !we_q) begin
        rdata <= mem_data_out;
      end
      if (gnt0) begin
        port_q       <= PORT0;
        we_q         <= we0;
        mem_position <= addr0;
        mem_data_in  <= wdata0;
        prio         <= PORT1;
      end else if (gnt1) begin
        port_q       <= PORT1;
        we_q         <= we1;
        mem_position <= addr1;
        mem_data_in  <= wdata1;
        prio         <= PORT0;
      end
    end
  end

endmodule
